// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC engine: rotation (sin/cos) or vectoring (magnitude/atan), one
// micro-rotation per cycle, with optional K gain compensation and a start/busy/done handshake.
module cordic_iter_engine #(
  parameter int WIDTH     = 32,
  parameter int FRAC      = 16,
  parameter int MAX_ITERS = 16,
  parameter int GAIN_COMP = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] y0,
  input  logic [WIDTH-1:0] z0,
  input  logic [4:0]       n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z
);

  typedef enum logic [2:0] {IDLE, LOAD, ITER, COMP, DONE} state_t;

  localparam logic signed [2*WIDTH-1:0] KGAIN = (2*WIDTH)'(39797);

  state_t                  state;
  logic signed [WIDTH-1:0] xr, yr, zr;
  logic                    moder;
  logic [4:0]              nclamp;
  logic [4:0]              iter;

  logic signed [WIDTH-1:0] xs, ys, at, xn, yn, zn;
  logic                    dpos;

  // Arctangent table in Q16, rescaled to the working fraction width.
  function automatic logic [WIDTH-1:0] atan_q(input logic [4:0] i);
    logic [16:0] q;
    case (i)
      5'd0:    q = 17'd51472;
      5'd1:    q = 17'd30386;
      5'd2:    q = 17'd16055;
      5'd3:    q = 17'd8150;
      5'd4:    q = 17'd4091;
      5'd5:    q = 17'd2047;
      5'd6:    q = 17'd1024;
      5'd7:    q = 17'd512;
      5'd8:    q = 17'd256;
      5'd9:    q = 17'd128;
      5'd10:   q = 17'd64;
      5'd11:   q = 17'd32;
      5'd12:   q = 17'd16;
      5'd13:   q = 17'd8;
      5'd14:   q = 17'd4;
      5'd15:   q = 17'd2;
      default: q = 17'd0;
    endcase
    return WIDTH'(q >> (16 - FRAC));
  endfunction

  // dpos=1 selects d=+1: rotation steers z toward 0, vectoring steers y toward 0.
  always_comb begin
    xs   = xr >>> iter;
    ys   = yr >>> iter;
    at   = atan_q(iter);
    dpos = moder ? yr[WIDTH-1] : ~zr[WIDTH-1];
    if (dpos) begin
      xn = xr - ys;
      yn = yr + xs;
      zn = zr - at;
    end else begin
      xn = xr + ys;
      yn = yr - xs;
      zn = zr + at;
    end
  end

  // Operands are captured with the accepted start so later input changes cannot leak in;
  // the DONE state publishes results and the done pulse follows on the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      x      <= '0;
      y      <= '0;
      z      <= '0;
      xr     <= '0;
      yr     <= '0;
      zr     <= '0;
      moder  <= 1'b0;
      nclamp <= 5'd0;
      iter   <= 5'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            xr     <= x0;
            yr     <= y0;
            zr     <= z0;
            moder  <= mode;
            nclamp <= (n > 5'(MAX_ITERS)) ? 5'(MAX_ITERS) : n;
            busy   <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          iter  <= 5'd0;
          state <= (nclamp == 5'd0) ? DONE : ITER;
        end
        ITER: begin
          xr <= xn;
          yr <= yn;
          zr <= zn;
          if (iter == nclamp - 5'd1) begin
            iter  <= 5'd0;
            state <= (GAIN_COMP != 0) ? COMP : DONE;
          end else begin
            iter <= iter + 5'd1;
          end
        end
        COMP: begin
          xr    <= WIDTH'(($signed({{WIDTH{xr[WIDTH-1]}}, xr}) * KGAIN) >>> 16);
          yr    <= WIDTH'(($signed({{WIDTH{yr[WIDTH-1]}}, yr}) * KGAIN) >>> 16);
          state <= DONE;
        end
        DONE: begin
          x     <= xr;
          y     <= yr;
          z     <= zr;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Directed bench for cordic_iter_engine: one instance without and one with gain
// compensation, driven from the same stimulus and checked against hand-computed values.
module tb_cordic_iter_engine;

  logic        clk = 1'b0;
  logic        rst, start, mode;
  logic [31:0] x0, y0, z0;
  logic [4:0]  n;

  logic        busyA, doneA, busyB, doneB;
  logic [31:0] xA, yA, zA, xB, yB, zB;

  int checks = 0;
  int errors = 0;
  int latA, latB, cntA, cntB, overlapA, overlapB;
  logic [31:0] capXA, capYA, capZA, capXB, capYB, capZB;

  always #5 clk = ~clk;

  cordic_iter_engine #(.WIDTH(32), .FRAC(16), .MAX_ITERS(16), .GAIN_COMP(0)) dutA (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .x0(x0), .y0(y0), .z0(z0), .n(n),
    .busy(busyA), .done(doneA), .x(xA), .y(yA), .z(zA)
  );

  cordic_iter_engine #(.WIDTH(32), .FRAC(16), .MAX_ITERS(16), .GAIN_COMP(1)) dutB (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .x0(x0), .y0(y0), .z0(z0), .n(n),
    .busy(busyB), .done(doneB), .x(xB), .y(yB), .z(zB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // Present one request with start for a single edge; returns 1ns after that edge (E0).
  task automatic applyStimulus(input logic m, input logic [31:0] xi, input logic [31:0] yi,
                               input logic [31:0] zi, input logic [4:0] ni);
    @(negedge clk);
    mode  = m;
    x0    = xi;
    y0    = yi;
    z0    = zi;
    n     = ni;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Observe both instances for a number of edges; while k < holdStart keep start
  // asserted and scramble the operands to show they are ignored mid-run.
  task automatic watch(input int cycles, input int holdStart);
    latA = 0; latB = 0; cntA = 0; cntB = 0; overlapA = 0; overlapB = 0;
    for (int k = 1; k <= cycles; k++) begin
      @(posedge clk);
      #1;
      if (doneA) begin
        cntA++;
        if (busyA) overlapA++;
        if (latA == 0) begin
          latA = k; capXA = xA; capYA = yA; capZA = zA;
        end
      end
      if (doneB) begin
        cntB++;
        if (busyB) overlapB++;
        if (latB == 0) begin
          latB = k; capXB = xB; capYB = yB; capZB = zB;
        end
      end
      if (k < holdStart) begin
        start = 1'b1;
        mode  = ~mode;
        x0    = $urandom;
        y0    = $urandom;
        z0    = $urandom;
        n     = 5'($urandom);
      end else begin
        start = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0;
    x0 = '0; y0 = '0; z0 = '0; n = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busyA", 32'(busyA), 0);
    checkOutput("reset doneA", 32'(doneA), 0);
    checkOutput("reset xA", xA, 0);
    checkOutput("reset yA", yA, 0);
    checkOutput("reset zA", zA, 0);
    checkOutput("reset busyB", 32'(busyB), 0);
    rst = 1'b0;

    // Rotation by ~pi/2 from (1,0)
    applyStimulus(1'b0, 32'd65536, 32'd0, 32'd102943, 5'd16);
    watch(30, 0);
    checkOutput("rot latA", latA, 18);
    checkOutput("rot latB", latB, 19);
    checkOutput("rot xA", capXA, 0);
    checkOutput("rot yA", capYA, 107923);
    checkOutput("rot zA", capZA, -2);
    checkOutput("rot xB", capXB, 0);
    checkOutput("rot yB", capYB, 65536);
    checkOutput("rot zB", capZB, -2);
    checkOutput("rot pulsesA", cntA, 1);
    checkOutput("rot pulsesB", cntB, 1);
    checkOutput("rot busy&doneA", overlapA, 0);
    checkOutput("rot busy&doneB", overlapB, 0);

    // Vectoring of (1,1)
    applyStimulus(1'b1, 32'd65536, 32'd65536, 32'd0, 5'd16);
    watch(30, 0);
    checkOutput("vec latA", latA, 18);
    checkOutput("vec xA", capXA, 152625);
    checkOutput("vec yA", capYA, -1);
    checkOutput("vec zA", capZA, 51473);
    checkOutput("vec xB", capXB, 92682);
    checkOutput("vec yB", capYB, -1);
    checkOutput("vec zB", capZB, 51473);

    // Zero iterations pass operands through, then a start during the done cycle
    applyStimulus(1'b0, 32'd5, 32'd7, 32'd9, 5'd0);
    watch(2, 0);
    checkOutput("n0 latA", latA, 2);
    checkOutput("n0 latB", latB, 2);
    checkOutput("n0 xA", capXA, 5);
    checkOutput("n0 yA", capYA, 7);
    checkOutput("n0 zA", capZA, 9);
    checkOutput("n0 xB", capXB, 5);
    x0 = 32'd11; y0 = 32'd13; z0 = -32'sd3; n = 5'd0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    watch(6, 0);
    checkOutput("b2b latA", latA, 2);
    checkOutput("b2b xA", capXA, 11);
    checkOutput("b2b yA", capYA, 13);
    checkOutput("b2b zA", capZA, -3);
    checkOutput("b2b pulsesA", cntA, 1);

    // n above the ceiling is clamped
    applyStimulus(1'b0, 32'd65536, 32'd0, 32'd102943, 5'd31);
    watch(30, 0);
    checkOutput("n31 latA", latA, 18);
    checkOutput("n31 latB", latB, 19);
    checkOutput("n31 yA", capYA, 107923);
    checkOutput("n31 zA", capZA, -2);

    // start held and operands scrambled while busy
    applyStimulus(1'b0, 32'd65536, 32'd0, 32'd102943, 5'd16);
    watch(40, 17);
    checkOutput("hold pulsesA", cntA, 1);
    checkOutput("hold pulsesB", cntB, 1);
    checkOutput("hold latA", latA, 18);
    checkOutput("hold xA", capXA, 0);
    checkOutput("hold yA", capYA, 107923);
    checkOutput("hold yB", capYB, 65536);
    checkOutput("hold stableY", yA, 107923);

    // Reset during iteration 5 aborts the run
    applyStimulus(1'b0, 32'd65536, 32'd0, 32'd102943, 5'd16);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort busyA", 32'(busyA), 0);
    checkOutput("abort doneA", 32'(doneA), 0);
    checkOutput("abort xA", xA, 0);
    checkOutput("abort yA", yA, 0);
    checkOutput("abort zA", zA, 0);
    checkOutput("abort busyB", 32'(busyB), 0);
    rst = 1'b0;
    watch(25, 0);
    checkOutput("abort no doneA", cntA, 0);
    checkOutput("abort no doneB", cntB, 0);

    applyStimulus(1'b0, 32'd65536, 32'd0, 32'd102943, 5'd16);
    watch(30, 0);
    checkOutput("rerun latA", latA, 18);
    checkOutput("rerun xA", capXA, 0);
    checkOutput("rerun yA", capYA, 107923);
    checkOutput("rerun zA", capZA, -2);
    checkOutput("rerun yB", capYB, 65536);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
